// File: rtl/sfa_route_pkg.sv
// Shared constants and types for the SFA route controller: switch directions,
// FSM state encoding and command field layout.
package sfa_route_pkg;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_E = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } route_state_e;

  // cmd_tdata layout: direction in the low bits, beat count above it
  localparam int CMD_DIR_LSB = 0;
  localparam int CMD_DIR_W   = 2;
  localparam int CMD_CNT_LSB = 2;

endpackage

// File: rtl/sfa_route_wdog.sv
// Stall counter for the route controller watchdog; expire holds once the
// counter has seen TMO_CYC consecutive stall cycles.
module sfa_route_wdog #(
  parameter int TMO_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(TMO_CYC))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(TMO_CYC));

endmodule

// File: rtl/sfa_route_ctrl.sv
// Route controller for the SFA 4-way output switch: accepts route commands,
// drives CONF and gates the upstream handshake. Optional watchdog: SFA_ROUTE_CTRL_WDOG_EN.
module sfa_route_ctrl
  import sfa_route_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1024
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cmd_tvalid,
  output logic             cmd_tready,
  input  logic [CNT_W+1:0] cmd_tdata,
  input  logic             up_tvalid,
  output logic             up_tready,
  output logic             sw_tvalid,
  input  logic             sw_tready,
  output logic [1:0]       CONF,
  output logic             busy,
  output logic             done,
  output logic             err
);

  route_state_e     state;
  logic [CNT_W-1:0] remain;
  logic [1:0]       conf_r;
  logic             done_r;
  logic             err_r;

  logic [1:0]       cmd_dir;
  logic [CNT_W-1:0] cmd_cnt;
  logic             stream;
  logic             cmd_hs;
  logic             beat;
  logic             wd_expire;

  assign cmd_dir = cmd_tdata[CMD_DIR_LSB +: CMD_DIR_W];
  assign cmd_cnt = cmd_tdata[CMD_CNT_LSB +: CNT_W];
  assign stream  = (state == STREAM);

  // Handshake gating: reset blocks every transfer in the cycle it is applied
  assign cmd_tready = ~stream & ~ARESET;
  assign sw_tvalid  = stream & ~ARESET & up_tvalid;
  assign up_tready  = stream & ~ARESET & sw_tready;

  assign cmd_hs = cmd_tvalid & cmd_tready;
  assign beat   = sw_tvalid & sw_tready;

`ifdef SFA_ROUTE_CTRL_WDOG_EN
  sfa_route_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk    (ACLK),
    .rst    (ARESET),
    .clr    (~stream | beat),
    .inc    (stream & ~beat),
    .expire (wd_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign wd_expire  = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      conf_r <= DIR_N;
      remain <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (state == IDLE) begin
        if (cmd_hs) begin
          conf_r <= cmd_dir;
          if (cmd_cnt == '0) begin
            done_r <= 1'b1;
          end else begin
            remain <= cmd_cnt;
            state  <= STREAM;
          end
        end
      end else begin
        // A beat wins over a simultaneous watchdog expiry so no data is dropped
        if (beat) begin
          remain <= remain - CNT_W'(1);
          if (remain == CNT_W'(1)) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end else if (wd_expire) begin
          state  <= IDLE;
          remain <= '0;
          err_r  <= 1'b1;
        end
      end
    end
  end

  assign CONF = conf_r;
  assign busy = stream;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_sfa_route_ctrl.sv
// Scoreboard bench for sfa_route_ctrl: directed scenarios plus randomized
// commands and flow control, checked against a burst-level reference model.
module tb_sfa_route_ctrl;
  import sfa_route_pkg::*;

  localparam int CNT_W = 16;
  localparam int TMO   = 8;
  localparam int K_ACC  = 0;
  localparam int K_BEAT = 1;
  localparam int K_DONE = 2;

  logic             clk = 1'b0;
  logic             ARESET = 1'b1;
  logic             cmd_tvalid = 1'b0;
  logic [CNT_W+1:0] cmd_tdata = '0;
  logic             up_tvalid = 1'b0;
  logic             sw_tready = 1'b0;
  logic             cmd_tready, up_tready, sw_tvalid, busy, done, err;
  logic [1:0]       CONF;

  int checks = 0;
  int errors = 0;
  bit rand_flow = 1'b0;

  typedef struct {
    int         kind;
    logic [1:0] dir;
    int         cnt;
    bit         last;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  sfa_route_ctrl #(
    .CNT_W   (CNT_W),
    .TMO_CYC (TMO)
  ) dut (
    .ACLK       (clk),
    .ARESET     (ARESET),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .cmd_tdata  (cmd_tdata),
    .up_tvalid  (up_tvalid),
    .up_tready  (up_tready),
    .sw_tvalid  (sw_tvalid),
    .sw_tready  (sw_tready),
    .CONF       (CONF),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_flow) begin
      up_tvalid = ($urandom_range(0, 3) != 0);
      sw_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Reference model: a command of count n yields an accept, n beats on its
  // direction, then a done pulse.
  task automatic send_cmd(input logic [1:0] dir, input int cnt);
    ev_t e;
    bit  ok;
    ok = 1'b0;
    e.kind = K_ACC; e.dir = dir; e.cnt = cnt; e.last = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < cnt; i++) begin
      e.kind = K_BEAT; e.last = (i == cnt - 1);
      sb.push_back(e);
    end
    e.kind = K_DONE; e.last = 1'b0;
    sb.push_back(e);
    cmd_tdata  = {CNT_W'(cnt), dir};
    cmd_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_tready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) bad("cmd_accept_timeout");
    tick();
    cmd_tvalid = 1'b0;
  endtask

  initial begin : monitor
    bit         done_due, prev_busy, post_rst, acc_pend;
    logic [1:0] acc_dir;
    int         acc_cnt, stall;
    ev_t        e;
    done_due = 0; prev_busy = 0; post_rst = 0; acc_pend = 0;
    acc_dir = 2'b00; acc_cnt = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (ARESET) begin
        chk("rst_cmd_tready", cmd_tready, 0);
        chk("rst_sw_tvalid", sw_tvalid, 0);
        chk("rst_up_tready", up_tready, 0);
        sb.delete();
        done_due = 0; prev_busy = 0; acc_pend = 0; stall = 0; post_rst = 1;
      end else begin
        if (post_rst) begin
          chk("post_rst_conf", CONF, DIR_N);
          chk("post_rst_busy", busy, 0);
          chk("post_rst_err", err, 0);
          post_rst = 0;
        end
        if (acc_pend) begin
          chk("acc_conf", CONF, acc_dir);
          chk("acc_busy", busy, acc_cnt != 0);
          acc_pend = 0;
        end
        chk("done_timing", done, done_due);
        done_due = 0;
        if (done) begin
          if (sb.size() == 0 || sb[0].kind != K_DONE) bad("done_unexpected");
          else begin
            e = sb.pop_front();
            chk("done_conf", CONF, e.dir);
          end
          chk("done_busy", busy, 0);
        end
        if (prev_busy && !busy && !done && !err) bad("busy_dropped");
        chk("cmd_tready_idle", cmd_tready, !busy);
        if (busy) begin
          chk("sw_tvalid_pass", sw_tvalid, up_tvalid);
          chk("up_tready_pass", up_tready, sw_tready);
        end else begin
          chk("sw_tvalid_idle", sw_tvalid, 0);
          chk("up_tready_idle", up_tready, 0);
        end
`ifdef SFA_ROUTE_CTRL_WDOG_EN
        if (err) begin
          chk("err_after_stall", (stall >= TMO) && (stall <= TMO + 1), 1);
          chk("err_busy", busy, 0);
          while (sb.size() != 0 && sb[0].kind != K_ACC) void'(sb.pop_front());
          stall = 0;
        end else if (stall > TMO + 3) begin
          bad("wdog_missing_err");
          stall = 0;
        end
`else
        chk("err_zero", err, 0);
`endif
        if (sw_tvalid && sw_tready) begin
          stall = 0;
          if (sb.size() == 0 || sb[0].kind != K_BEAT) bad("beat_unexpected");
          else begin
            e = sb.pop_front();
            chk("beat_conf", CONF, e.dir);
            done_due = e.last;
          end
        end else if (busy) begin
          stall++;
        end else begin
          stall = 0;
        end
        if (cmd_tvalid && cmd_tready) begin
          if (sb.size() == 0 || sb[0].kind != K_ACC) bad("acc_unexpected");
          else begin
            e = sb.pop_front();
            acc_pend = 1; acc_dir = e.dir; acc_cnt = e.cnt;
            if (e.cnt == 0) done_due = 1;
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    logic [4:0] pat;
    bit         drained;
    repeat (3) @(posedge clk);
    #1 ARESET = 1'b0;

    // Single burst with continuous flow
    up_tvalid = 1'b1; sw_tready = 1'b1;
    send_cmd(DIR_E, 4);
    repeat (6) tick();

    // Switch backpressure pattern 1,0,1,0,1
    pat = 5'b10101;
    send_cmd(DIR_S, 3);
    for (int i = 0; i < 5; i++) begin
      sw_tready = pat[i];
      tick();
    end
    sw_tready = 1'b1;
    repeat (3) tick();

    // Back-to-back commands
    send_cmd(DIR_N, 2);
    send_cmd(DIR_W, 2);
    repeat (5) tick();

    // Zero-length command
    send_cmd(DIR_W, 0);
    repeat (3) tick();

    // Reset in the middle of a 5-beat burst, after 2 beats
    send_cmd(DIR_S, 5);
    tick();
    tick();
    ARESET = 1'b1; up_tvalid = 1'b0;
    tick();
    ARESET = 1'b0; up_tvalid = 1'b1;
    send_cmd(DIR_E, 2);
    repeat (4) tick();

    // Stall after one beat
    send_cmd(DIR_E, 4);
    tick();
    sw_tready = 1'b0;
    repeat (20) tick();
    sw_tready = 1'b1;
    repeat (6) tick();

    // Longer burst
    send_cmd(DIR_N, 40);
    repeat (3) tick();

    // Randomized commands and flow control
    rand_flow = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_flow = 1'b0;
    up_tvalid = 1'b1; sw_tready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    if (!drained) bad("drain_timeout");
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
